// File: rtl/key_value_counter_pkg.sv
// key_value_counter_pkg: key indices and shared tick default for the key input stage
package key_value_counter_pkg;
  localparam int TICK_CYCLES_DEF = 50_000;
  localparam int N_KEYS = 3;
  localparam int VALUE_W = 8;
  typedef enum logic [1:0] {KEY_UP, KEY_DN, KEY_CLR} key_idx_e;
endpackage

// File: rtl/key_value_counter_if.sv
// key_value_counter_if: raw buttons in, debounced keys and counter value out
interface key_value_counter_if;
  import key_value_counter_pkg::*;
  logic key_up_n;
  logic key_dn_n;
  logic key_clr_n;
  logic [VALUE_W-1:0] value;
  logic changed;
  logic [N_KEYS-1:0] keys_db;
  modport master (output key_up_n, key_dn_n, key_clr_n, input value, changed, keys_db);
  modport slave (input key_up_n, key_dn_n, key_clr_n, output value, changed, keys_db);
endinterface

// File: rtl/key_value_counter_key_debounce.sv
// key_debounce: 2-FF synchronizer and tick-sampled stability filter for one active-low key
module key_debounce #(
  parameter int DEBOUNCE_MS = 20
) (
  input  logic clk_50M,
  input  logic rst,
  input  logic i_key_n,
  input  logic i_tick,
  output logic o_pressed
);
  localparam int CW = $clog2(DEBOUNCE_MS + 1);
  localparam logic [CW-1:0] L_DONE = CW'(DEBOUNCE_MS);
  logic [1:0] r_sync;
  logic [CW-1:0] r_cnt;
  logic r_db;
  logic w_diff;
  logic w_done;
  logic [CW-1:0] w_cnt1;
  assign w_diff = r_sync[1] != r_db;
  assign w_cnt1 = r_cnt + CW'(1);
  assign w_done = w_diff && w_cnt1 == L_DONE;
  assign o_pressed = r_db;
  // synchronize pressed-high level; on each tick count disagreeing ticks and flip after DEBOUNCE_MS
  always_ff @(posedge clk_50M) begin
    if (rst) begin
      r_sync <= '0;
      r_cnt <= '0;
      r_db <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], ~i_key_n};
      if (i_tick) begin
        r_cnt <= (!w_diff || w_done) ? '0 : w_cnt1;
        r_db <= w_done ? r_sync[1] : r_db;
      end
    end
  end
endmodule

// File: rtl/key_value_counter.sv
// key_value_counter: debounced up/down/clear keys driving a saturating 0..MAX_VAL value with auto-repeat
module key_value_counter
  import key_value_counter_pkg::*;
#(
  parameter int TICK_CYCLES     = TICK_CYCLES_DEF,
  parameter int DEBOUNCE_MS     = 20,
  parameter int REPEAT_DELAY_MS = 500,
  parameter int REPEAT_RATE_MS  = 100,
  parameter int MAX_VAL         = 255
) (
  input logic clk_50M,
  input logic rst,
  key_value_counter_if.slave bus
);
  localparam int PW = $clog2(TICK_CYCLES);
  localparam int HW = $clog2(REPEAT_DELAY_MS + REPEAT_RATE_MS + 1);
  localparam logic [PW-1:0] L_TICK = PW'(TICK_CYCLES - 1);
  localparam logic [HW-1:0] L_FIRST = HW'(REPEAT_DELAY_MS);
  localparam logic [HW-1:0] L_WRAP = HW'(REPEAT_DELAY_MS + REPEAT_RATE_MS);
  localparam logic [VALUE_W-1:0] L_MAX = VALUE_W'(MAX_VAL);
  logic [PW-1:0] r_presc;
  logic [HW-1:0] r_hold;
  logic [N_KEYS-1:0] r_db_prev;
  logic [VALUE_W-1:0] r_value;
  logic r_changed;
  logic w_tick;
  logic [N_KEYS-1:0] w_raw_n;
  logic [N_KEYS-1:0] w_db;
  logic [N_KEYS-1:0] w_edge;
  logic [HW-1:0] w_h1;
  logic w_one;
  logic w_rep;
  logic w_inc;
  logic w_dec;
  assign w_tick = r_presc == L_TICK;
  assign w_raw_n = {bus.key_clr_n, bus.key_dn_n, bus.key_up_n};
  assign w_edge = w_db & ~r_db_prev;
  assign w_one = w_db[KEY_UP] ^ w_db[KEY_DN];
  assign w_h1 = r_hold + HW'(1);
  assign w_rep = w_one && w_tick && (w_h1 == L_FIRST || w_h1 == L_WRAP);
  assign w_inc = w_one && w_db[KEY_UP] && (w_edge[KEY_UP] || w_rep) && r_value < L_MAX;
  assign w_dec = w_one && w_db[KEY_DN] && (w_edge[KEY_DN] || w_rep) && r_value != '0;
  assign bus.value = r_value;
  assign bus.changed = r_changed;
  assign bus.keys_db = w_db;
  for (genvar k = 0; k < N_KEYS; k++) begin : g_key
    key_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_db (
      .clk_50M  (clk_50M),
      .rst      (rst),
      .i_key_n  (w_raw_n[k]),
      .i_tick   (w_tick),
      .o_pressed(w_db[k])
    );
  end
  // 1 ms prescaler shared by all debouncers and the hold counter
  always_ff @(posedge clk_50M) begin
    r_presc <= (rst || w_tick) ? '0 : r_presc + PW'(1);
  end
  // hold ticks of a single up/dn key; folds back one repeat period so it never overflows
  always_ff @(posedge clk_50M) begin
    if (rst || !w_one) r_hold <= '0;
    else if (w_tick) r_hold <= (w_h1 == L_WRAP) ? L_FIRST : w_h1;
  end
  // value register: clear dominates, then up, then down; changed only on a real update
  always_ff @(posedge clk_50M) begin
    if (rst) begin
      r_db_prev <= '0;
      r_value <= '0;
      r_changed <= 1'b0;
    end else begin
      r_db_prev <= w_db;
      r_value <= w_db[KEY_CLR] ? '0 : w_inc ? r_value + VALUE_W'(1) : w_dec ? r_value - VALUE_W'(1) : r_value;
      r_changed <= w_db[KEY_CLR] ? (w_edge[KEY_CLR] && r_value != '0) : (w_inc || w_dec);
    end
  end
endmodule
